muldiv_unit: RTL and testbench

- Parametrised, iterative multiply/divide unit implementing the eight RV32M operations for any `XLEN`.
- Sits beside `alu` in the execute stage. `alu` is purely combinational; this block is sequential and multi-cycle.
- Operands are taken with a valid/ready handshake, processed one bit per cycle (radix-2), and the result is held under output backpressure.
- Divide-by-zero and signed-overflow cases are detected up front and complete early.

---
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the eight RV32M operations.
// Operands are held as magnitudes; the sign is applied once when the result is written.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    input  logic [2:0]      funct3,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned PW = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [2:0]      funct_q, funct_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            out_valid_q, out_valid_d;

    // Operand decode at acceptance
    logic            is_div, r1_signed, r2_signed, neg1, neg2, res_neg;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    assign is_div    = funct3[2];
    assign r1_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
    assign r2_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign neg1      = r1_signed & r1[XLEN-1];
    assign neg2      = r2_signed & r2[XLEN-1];
    assign mag1      = neg1 ? -r1 : r1;
    assign mag2      = neg2 ? -r2 : r2;
    assign res_neg   = (funct3 == 3'b110) ? neg1 : (neg1 ^ neg2);

    assign div_zero    = is_div && (r2 == '0);
    assign div_ovf     = is_div && !funct3[0] && (r1 == MIN_NEG) && (r2 == '1);
    assign special     = div_zero || div_ovf;
    assign special_res = div_zero ? (funct3[1] ? r1 : '1) : (funct3[1] ? '0 : r1);

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [PW-1:0]   mul_next, div_next, step, step_signed;
    logic [XLEN-1:0] quo, rem, final_res;

    assign mul_sum   = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
    assign mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    assign div_shift = {prod_q[PW-1:XLEN], prod_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, a_q};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  prod_q[XLEN-2:0], 1'b1};
    assign step        = funct_q[2] ? div_next : mul_next;
    assign step_signed = neg_q ? -step : step;
    assign quo         = step[XLEN-1:0];
    assign rem         = step[PW-1:XLEN];

    always_comb begin
        case (funct_q)
            3'b000:                 final_res = step_signed[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = step_signed[PW-1:XLEN];
            3'b100, 3'b101:         final_res = neg_q ? -quo : quo;
            default:                final_res = neg_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        funct_d     = funct_q;
        a_d         = a_q;
        prod_d      = prod_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        funct_d = funct3;
                        a_d     = is_div ? mag2 : mag1;
                        prod_d  = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                        neg_d   = res_neg;
                        cnt_d   = CW'(XLEN - 1);
                        if (special) begin
                            result_d    = special_res;
                            out_valid_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    prod_d = step;
                    if (cnt_q == '0) begin
                        result_d    = final_res;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            funct_q     <= '0;
            a_q         <= '0;
            prod_q      <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct_q     <= funct_d;
            a_q         <= a_d;
            prod_q      <= prod_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_CALC);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit instance for the main scenarios and an
// 8-bit instance for the narrow-width repeat of the arithmetic cases.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] r1, r2, result;
    logic [2:0]  funct3;
    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_busy;
    logic [7:0]  e_r1, e_r2, e_result;
    logic [2:0]  e_funct3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .r1(r1), .r2(r2), .funct3(funct3), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .r1(e_r1), .r2(e_r2), .funct3(e_funct3), .flush(flush), .out_valid(e_out_valid),
        .out_ready(e_out_ready), .result(e_result), .busy(e_busy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Present a request in one cycle; operands are scrambled after the acceptance edge.
    task automatic issue32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct3 = f; r1 = a; r2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; funct3 = 3'b111; r1 = 32'hA5A5_5A5A; r2 = 32'h5A5A_A5A5;
    endtask

    // lat = rising edges after the acceptance edge until out_valid is seen (-1 on timeout)
    task automatic wait32(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        if (out_valid) begin
            lat = 0;
        end else begin
            bcnt = int'(busy);
            for (int i = 1; i <= 200; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) begin
                    lat = i;
                    break;
                end
                bcnt += int'(busy);
            end
        end
    endtask

    task automatic take32();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int lat);
        @(negedge clk);
        e_funct3 = f; e_r1 = a; e_r2 = b; e_in_valid = 1'b1;
        @(posedge clk);
        #1;
        e_in_valid = 1'b0; e_r1 = 8'h3C; e_r2 = 8'hC3;
        lat = -1;
        if (e_out_valid) begin
            lat = 0;
        end else begin
            for (int i = 1; i <= 50; i++) begin
                @(posedge clk);
                #1;
                if (e_out_valid) begin
                    lat = i;
                    break;
                end
            end
        end
        res = e_result;
        @(negedge clk);
        e_out_ready = 1'b1;
        @(posedge clk);
        #1;
        e_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp += 4;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
    endtask

    task automatic test_mul();
        logic [2:0]  fs [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        logic [31:0] as [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] es [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            issue32(fs[i], as[i], bs[i]);
            wait32(lat, bc);
            n_cmp += 3;
            if (result !== es[i]) begin n_bad++; $display("FAIL mul%0d_result got %h want %h", i, result, es[i]); end
            if (lat !== 32) begin n_bad++; $display("FAIL mul%0d_latency got %0d want 32", i, lat); end
            if (bc !== 32) begin n_bad++; $display("FAIL mul%0d_busy_cycles got %0d want 32", i, bc); end
            take32();
        end
    endtask

    task automatic test_div();
        logic [2:0]  fs [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] es [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            issue32(fs[i], as[i], bs[i]);
            wait32(lat, bc);
            n_cmp += 2;
            if (result !== es[i]) begin n_bad++; $display("FAIL div%0d_result got %h want %h", i, result, es[i]); end
            if (lat !== 32) begin n_bad++; $display("FAIL div%0d_latency got %0d want 32", i, lat); end
            take32();
        end
    endtask

    task automatic test_special();
        logic [2:0]  fs [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] as [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] es [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            issue32(fs[i], as[i], bs[i]);
            wait32(lat, bc);
            n_cmp += 3;
            if (result !== es[i]) begin n_bad++; $display("FAIL spc%0d_result got %h want %h", i, result, es[i]); end
            if (lat !== 0) begin n_bad++; $display("FAIL spc%0d_extra_edges got %0d want 0", i, lat); end
            if (bc !== 0) begin n_bad++; $display("FAIL spc%0d_busy_cycles got %0d want 0", i, bc); end
            take32();
        end
    endtask

    task automatic test_backpressure();
        int lat, bc;
        issue32(3'b000, 32'd3, 32'd5);
        wait32(lat, bc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp += 3;
            if (result !== 32'd15) begin n_bad++; $display("FAIL bp_hold%0d_result got %h want 0000000f", i, result); end
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold%0d_in_ready got %b want 0", i, in_ready); end
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold%0d_out_valid got %b want 1", i, out_valid); end
        end
        take32();
        n_cmp += 2;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_handoff_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_handoff_out_valid got %b want 0", out_valid); end
        issue32(3'b000, 32'd6, 32'd7);
        n_cmp += 1;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_next_accept_busy got %b want 1", busy); end
        wait32(lat, bc);
        n_cmp += 1;
        if (result !== 32'd42) begin n_bad++; $display("FAIL bp_next_result got %h want 0000002a", result); end
        take32();
    endtask

    task automatic test_flush();
        int seen;
        int lat, bc;
        issue32(3'b100, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_cmp += 2;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_calc_busy got %b want 0", busy); end
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_calc_in_ready got %b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            seen += int'(out_valid);
        end
        n_cmp += 1;
        if (seen !== 0) begin n_bad++; $display("FAIL flush_calc_no_result got %0d valid cycles want 0", seen); end

        @(negedge clk);
        funct3 = 3'b101; r1 = 32'd5; r2 = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_accept_out_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_accept_in_ready got %b want 1", in_ready); end

        issue32(3'b101, 32'd5, 32'd0);
        wait32(lat, bc);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_done_out_valid got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_done_in_ready got %b want 1", in_ready); end
        if (result !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL flush_done_result_kept got %h want ffffffff", result); end
    endtask

    task automatic test_reset_mid();
        issue32(3'b000, 32'd3, 32'd4);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        if (result !== 32'h0) begin n_bad++; $display("FAIL rstmid_result got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_cmp += 2;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_release_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_release_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_xlen8();
        logic [2:0] fs [12] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110,
                                3'b101, 3'b111, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [7:0] as [12] = '{8'h0F, 8'h80, 8'hFF, 8'hFF, 8'hF9, 8'hF9,
                                8'h64, 8'h64, 8'h05, 8'h05, 8'h80, 8'h80};
        logic [7:0] bs [12] = '{8'h11, 8'h80, 8'hFF, 8'hFF, 8'h02, 8'h02,
                                8'h07, 8'h07, 8'h00, 8'h00, 8'hFF, 8'hFF};
        logic [7:0] es [12] = '{8'hFF, 8'h40, 8'hFE, 8'hFF, 8'hFD, 8'hFF,
                                8'h0E, 8'h02, 8'hFF, 8'h05, 8'h80, 8'h00};
        int         ls [12] = '{8, 8, 8, 8, 8, 8, 8, 8, 0, 0, 0, 0};
        logic [7:0] res;
        int         lat;
        for (int i = 0; i < 12; i++) begin
            run8(fs[i], as[i], bs[i], res, lat);
            n_cmp += 2;
            if (res !== es[i]) begin n_bad++; $display("FAIL x8_%0d_result got %h want %h", i, res, es[i]); end
            if (lat !== ls[i]) begin n_bad++; $display("FAIL x8_%0d_latency got %0d want %0d", i, lat, ls[i]); end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; r1 = '0; r2 = '0; funct3 = '0;
        e_in_valid = 1'b0; e_out_ready = 1'b0; e_r1 = '0; e_r2 = '0; e_funct3 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_xlen8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
